// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 receiver for the chip's UART0 TX line, feeding a small byte FIFO.
// Framing errors and FIFO overflow are reported as single-cycle pulses.
module uart_rx_monitor #(
    parameter int ClkFreq   = 50_000_000,
    parameter int BaudRate  = 921_600,
    parameter int FifoDepth = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         enable_i,
    input  logic                         rx_i,
    output logic [7:0]                   byte_o,
    output logic                         byte_valid_o,
    input  logic                         byte_ready_i,
    output logic                         frame_err_o,
    output logic                         overflow_o,
    output logic [$clog2(FifoDepth):0]   fifo_level_o
);
    localparam int ClksPerBit = ClkFreq / BaudRate;
    localparam int HalfBit    = ClksPerBit / 2;
    localparam int CntW       = $clog2(ClksPerBit + 1);
    localparam int PtrW       = $clog2(FifoDepth);
    localparam int LvlW       = PtrW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

    logic            sync1_q, rxs_q, rxs_prev_q;
    logic            fall;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            start_tick, bit_tick;
    logic            push_d, push_q, ferr_d, ferr_q;
    logic [7:0]      mem_q [FifoDepth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q, level_d;
    logic            full, pop, wr_en, ovf_d, ovf_q;

    // Preset to idle-high so releasing reset cannot look like a start edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= rx_i;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    assign fall       = rxs_prev_q & ~rxs_q;
    assign start_tick = (cnt_q == CntW'(HalfBit - 1));
    assign bit_tick   = (cnt_q == CntW'(ClksPerBit - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (fall) state_d = START;
                START:   if (start_tick) state_d = rxs_q ? IDLE : DATA;
                DATA:    if (bit_tick && bit_idx_q == 3'd7) state_d = STOP;
                STOP:    if (bit_tick) state_d = rxs_q ? IDLE : BREAK;
                BREAK:   if (rxs_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Counter restarts on every sample; a disabled receiver flags and pushes nothing.
    always_comb begin
        cnt_d     = '0;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_d    = 1'b0;
        if (enable_i) begin
            case (state_q)
                IDLE:  bit_idx_d = '0;
                START: if (!start_tick) cnt_d = cnt_q + 1'b1;
                DATA: begin
                    if (bit_tick) begin
                        shift_d   = {rxs_q, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        push_d = rxs_q;
                        ferr_d = ~rxs_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    // shift_q is stable for the cycle after the stop sample, so it doubles as write data.
    assign full  = (level_q == LvlW'(FifoDepth));
    assign pop   = (level_q != '0) & byte_ready_i;
    assign wr_en = push_q & (~full | pop);
    assign ovf_d = push_q & full & ~pop;

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop)      level_d = level_q + 1'b1;
        else if (pop && !wr_en) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign byte_valid_o = (level_q != '0);
    assign byte_o       = byte_valid_o ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_err_o  = ferr_q;
    assign overflow_o   = ovf_q;
    assign fifo_level_o = level_q;
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed/randomised bench for uart_rx_monitor; expected bytes come from a queue model of
// the line protocol and FIFO rules.
`timescale 1ns/1ps
module tb_uart_rx_monitor;
    localparam int BIT   = 50_000_000 / 921_600;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst, enable, rx, ready;
    logic [7:0] byte_o;
    logic       byte_valid, frame_err, overflow;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0, ov_cnt = 0, both_cnt = 0;
    int exp_fe = 0, exp_ov = 0;
    int edges;
    logic [7:0] mq[$];
    logic [7:0] rb, last;

    uart_rx_monitor dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .rx_i         (rx),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid),
        .byte_ready_i (ready),
        .frame_err_o  (frame_err),
        .overflow_o   (overflow),
        .fifo_level_o (level)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overflow === 1'b1) ov_cnt++;
        if (frame_err === 1'b1 && overflow === 1'b1) both_cnt++;
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the line at the stop-bit level when done.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(BIT);
        end
        rx = stop_bit;
        idle(BIT);
    endtask

    // Reference: a good frame is queued unless the FIFO is full, in which case it is dropped.
    task automatic model_push(input logic [7:0] b);
        if (mq.size() == DEPTH) exp_ov++;
        else mq.push_back(b);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, byte_valid, 1);
        check({tag, "_data"}, byte_o, exp);
        last  = byte_o;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) pop_check(tag, mq.pop_front());
        check({tag, "_level0"}, level, 0);
        check({tag, "_empty_byte"}, byte_o, 8'h00);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; rx = 1'b1; ready = 1'b0;
        idle(3);
        check("rst_valid", byte_valid, 0);
        check("rst_byte", byte_o, 0);
        check("rst_level", level, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        idle(20);
        check("post_rst_valid", byte_valid, 0);

        // First edge that samples rx low counts as cycle 0.
        fork
            send_frame(8'h55, 1'b1);
            begin
                edges = 0;
                while (byte_valid !== 1'b1 && edges < 2000) begin
                    @(posedge clk);
                    edges++;
                    #1;
                end
            end
        join
        model_push(8'h55);
        check("latency", edges - 1, 516);
        check("t1_level", level, 1);
        drain("t1");

        // Back-to-back frames, no idle bit between them.
        send_frame(8'h41, 1'b1); model_push(8'h41);
        send_frame(8'h42, 1'b1); model_push(8'h42);
        send_frame(8'h43, 1'b1); model_push(8'h43);
        for (int i = 0; i < 3; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1);
            model_push(rb);
        end
        idle(5);
        check("t2_level", level, 6);
        drain("t2");
        check("t2_ferr", fe_cnt, exp_fe);

        // Bad stop bit followed by a held-low line.
        send_frame(8'hA5, 1'b0);
        exp_fe++;
        idle(3 * BIT);
        rx = 1'b1;
        idle(2 * BIT);
        check("t3_ferr", fe_cnt, exp_fe);
        check("t3_empty", byte_valid, 0);
        send_frame(8'h3C, 1'b1); model_push(8'h3C);
        idle(5);
        drain("t3");

        // Short glitch must not start a frame.
        rx = 1'b0; idle(20); rx = 1'b1; idle(100);
        check("t4_valid", byte_valid, 0);
        check("t4_ferr", fe_cnt, exp_fe);
        check("t4_ovf", ov_cnt, exp_ov);
        send_frame(8'hFF, 1'b1); model_push(8'hFF);
        idle(5);
        drain("t4");

        // Fill, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            rb = 8'($urandom);
            send_frame(rb, 1'b1);
            model_push(rb);
        end
        idle(5);
        check("t5_full_level", level, DEPTH);
        send_frame(8'h99, 1'b1); model_push(8'h99);
        idle(5);
        check("t5_ovf", ov_cnt, exp_ov);
        check("t5_level", level, DEPTH);
        check("t5_head", byte_o, mq[0]);

        // Pop on the very cycle the push lands: accepted, no overflow.
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (516) @(posedge clk);
                @(negedge clk);
                check("t5_coinc_head", byte_o, mq[0]);
                ready = 1'b1;
                @(negedge clk);
                ready = 1'b0;
            end
        join
        void'(mq.pop_front());
        model_push(8'h99);
        idle(5);
        check("t5_coinc_ovf", ov_cnt, exp_ov);
        check("t5_coinc_level", level, DEPTH);
        drain("t5");
        check("t5_last", last, 8'h99);

        // Reset mid-DATA with a byte already buffered.
        send_frame(8'h5A, 1'b1); model_push(8'h5A);
        rx = 1'b0; idle(BIT);
        rx = 1'b0; idle(BIT);
        rx = 1'b1; idle(BIT);
        rx = 1'b0; idle(BIT / 2);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", byte_valid, 0);
        check("t6_rst_level", level, 0);
        check("t6_rst_byte", byte_o, 0);
        mq.delete();
        rx = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2 * BIT);
        check("t6_after_valid", byte_valid, 0);
        check("t6_after_ferr", fe_cnt, exp_fe);
        send_frame(8'h34, 1'b1); model_push(8'h34);
        idle(5);
        drain("t6");

        // Enable dropped mid-frame: nothing received, no flags.
        rb = 8'($urandom);
        fork
            send_frame(rb, 1'b1);
            begin idle(200); enable = 1'b0; end
        join
        idle(BIT);
        enable = 1'b1;
        idle(BIT);
        check("t7_valid", byte_valid, 0);
        check("t7_ferr", fe_cnt, exp_fe);
        rb = 8'($urandom);
        send_frame(rb, 1'b1); model_push(rb);
        idle(5);
        drain("t7");

        check("final_ovf", ov_cnt, exp_ov);
        check("final_ferr", fe_cnt, exp_fe);
        check("never_both", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
